// File: rtl/usb_utmi_pkg.sv
// usb_utmi_pkg
//   Shared UTMI-side types for the FS UTM: recovered line state encoding,
//   the bus-level sequencer state, and FS 48 MHz timing constants that the
//   bus controller parameters default to.
package usb_utmi_pkg;

  typedef enum logic [1:0] {
    LS_SE0 = 2'd0,
    LS_DJ  = 2'd1,
    LS_DK  = 2'd2,
    LS_SE1 = 2'd3
  } utmi_line_state_t;

  typedef enum logic [2:0] {
    ST_DETACHED  = 3'd0,
    ST_ATTACHED  = 3'd1,
    ST_BUS_RESET = 3'd2,
    ST_ACTIVE    = 3'd3,
    ST_SUSPEND   = 3'd4,
    ST_RESUME    = 3'd5,
    ST_WAKEUP    = 3'd6
  } usb_bus_state_t;

  // FS timing at 48 MHz
  localparam int unsigned FS_CONNECT_DLY_CYC = 4800;    // 100 us
  localparam int unsigned FS_SE0_RST_CYC     = 120;     // 2.5 us
  localparam int unsigned FS_IDLE_SUSP_CYC   = 144000;  // 3 ms
  localparam int unsigned FS_WAKEUP_IDLE_CYC = 240000;  // 5 ms
  localparam int unsigned FS_WAKEUP_DRV_CYC  = 96000;   // 2 ms
  localparam int unsigned FS_CNT_W           = 18;

endpackage

// File: rtl/usb_bus_ctrl.sv
// usb_bus_ctrl
//   Bus-level sequencer for the FS UTM. Owns the D+ pull-up (attach/detach),
//   detects host bus reset, suspend and host resume from the recovered line
//   state, and sequences device remote wakeup by asking the transmitter to
//   drive K.
// Ports:
//   clk               48 MHz clock
//   rst               async reset, active low
//   connect_en        soft-connect request
//   line_state        utmi_line_state_t from usb_utm
//   remote_wakeup_req single-cycle remote wakeup request
//   pu                D+ pull-up enable
//   drive_k           transmitter K drive request
//   bus_reset         level, high while bus reset is seen
//   suspend           level, high while suspended (incl. resume/wakeup)
//   resume_pulse      one-cycle strobe on leaving suspend via resume
//   bus_state         current usb_bus_state_t
module usb_bus_ctrl
  import usb_utmi_pkg::*;
#(
  parameter int unsigned CONNECT_DLY_CYC = FS_CONNECT_DLY_CYC,
  parameter int unsigned SE0_RST_CYC     = FS_SE0_RST_CYC,
  parameter int unsigned IDLE_SUSP_CYC   = FS_IDLE_SUSP_CYC,
  parameter int unsigned WAKEUP_IDLE_CYC = FS_WAKEUP_IDLE_CYC,
  parameter int unsigned WAKEUP_DRV_CYC  = FS_WAKEUP_DRV_CYC,
  parameter int unsigned CNT_W           = FS_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       connect_en,
  input  logic [1:0] line_state,
  input  logic       remote_wakeup_req,
  output logic       pu,
  output logic       drive_k,
  output logic       bus_reset,
  output logic       suspend,
  output logic       resume_pulse,
  output logic [2:0] bus_state
);

  // Thresholds are "last cycle" values: cnt holds run length - 1 while the
  // run is in progress, so reaching N-1 means N qualifying cycles seen.
  localparam logic [CNT_W-1:0] CONN_LAST = CNT_W'(CONNECT_DLY_CYC - 1);
  localparam logic [CNT_W-1:0] SE0_LAST  = CNT_W'(SE0_RST_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_SUSP_CYC - 1);
  localparam logic [CNT_W-1:0] WAKE_MIN  = CNT_W'(WAKEUP_IDLE_CYC);
  localparam logic [CNT_W-1:0] DRV_LAST  = CNT_W'(WAKEUP_DRV_CYC - 1);

  usb_bus_state_t   state, nxt;
  utmi_line_state_t ls_q, ls_in;
  logic [CNT_W-1:0] cnt, nxt_cnt, cnt_inc;
  logic             ls_chg, se0_edge;
  logic             is_se0, is_j, is_k;

  assign ls_in    = utmi_line_state_t'(line_state);
  // ls_q and cnt update on the same edge, so a change clears cnt in step
  // with the new run starting in ls_q.
  assign ls_chg   = (ls_in != ls_q);
  assign se0_edge = ls_chg && (ls_in == LS_SE0 || ls_q == LS_SE0);
  assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;
  assign is_se0   = (ls_q == LS_SE0);
  assign is_j     = (ls_q == LS_DJ);
  assign is_k     = (ls_q == LS_DK);

  always_comb begin
    nxt     = state;
    nxt_cnt = cnt_inc;
    unique case (state)
      ST_DETACHED: begin
        nxt_cnt = connect_en ? cnt_inc : '0;
        if (connect_en && cnt == CONN_LAST) nxt = ST_ATTACHED;
      end
      ST_ATTACHED: begin
        // only a bus reset matters before the host has enumerated us
        nxt_cnt = ls_chg ? '0 : cnt_inc;
        if (is_se0 && cnt >= SE0_LAST) nxt = ST_BUS_RESET;
      end
      ST_BUS_RESET: begin
        if (!is_se0) nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        nxt_cnt = ls_chg ? '0 : cnt_inc;
        if (is_se0 && cnt >= SE0_LAST)     nxt = ST_BUS_RESET;
        else if (is_j && cnt >= IDLE_LAST) nxt = ST_SUSPEND;
      end
      ST_SUSPEND: begin
        // cnt is time suspended, but restarts around SE0 so the same counter
        // can qualify a bus reset; an SE0 glitch only delays wakeup eligibility
        nxt_cnt = se0_edge ? '0 : cnt_inc;
        if (is_se0 && cnt >= SE0_LAST)                  nxt = ST_BUS_RESET;
        else if (is_k)                                  nxt = ST_RESUME;
        else if (remote_wakeup_req && cnt >= WAKE_MIN)  nxt = ST_WAKEUP;
      end
      ST_RESUME: begin
        // EOP after host K ends resume
        if (is_se0) nxt = ST_ACTIVE;
      end
      ST_WAKEUP: begin
        if (cnt >= DRV_LAST) nxt = ST_RESUME;
      end
      default: nxt = ST_DETACHED;
    endcase
    if (!connect_en) nxt = ST_DETACHED;
    if (nxt != state) nxt_cnt = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_DETACHED;
      cnt          <= '0;
      ls_q         <= LS_DJ;
      pu           <= 1'b0;
      drive_k      <= 1'b0;
      bus_reset    <= 1'b0;
      suspend      <= 1'b0;
      resume_pulse <= 1'b0;
    end else begin
      state        <= nxt;
      cnt          <= nxt_cnt;
      ls_q         <= ls_in;
      pu           <= (nxt != ST_DETACHED);
      drive_k      <= (nxt == ST_WAKEUP);
      bus_reset    <= (nxt == ST_BUS_RESET);
      suspend      <= (nxt == ST_SUSPEND) || (nxt == ST_RESUME) || (nxt == ST_WAKEUP);
      resume_pulse <= (state == ST_RESUME) && (nxt == ST_ACTIVE);
    end
  end

  assign bus_state = state;

endmodule

// File: tb/tb_usb_bus_ctrl.sv
// Directed bench for usb_bus_ctrl with shortened timing parameters.
// Inputs change and outputs are sampled on the falling edge.
module tb_usb_bus_ctrl;

  localparam int CD = 20;  // connect delay
  localparam int SR = 8;   // SE0 reset
  localparam int IS = 40;  // idle to suspend
  localparam int WI = 60;  // suspend time before wakeup allowed
  localparam int WD = 30;  // K drive length

  localparam logic [1:0] SE0 = 2'd0, J = 2'd1, K = 2'd2, SE1 = 2'd3;

  logic       clk, rst, connect_en, remote_wakeup_req;
  logic [1:0] line_state;
  logic       pu, drive_k, bus_reset, suspend, resume_pulse;
  logic [2:0] bus_state;

  int n_chk = 0;
  int n_pass = 0;

  usb_bus_ctrl #(
    .CONNECT_DLY_CYC(CD), .SE0_RST_CYC(SR), .IDLE_SUSP_CYC(IS),
    .WAKEUP_IDLE_CYC(WI), .WAKEUP_DRV_CYC(WD), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .connect_en(connect_en), .line_state(line_state),
    .remote_wakeup_req(remote_wakeup_req), .pu(pu), .drive_k(drive_k),
    .bus_reset(bus_reset), .suspend(suspend), .resume_pulse(resume_pulse),
    .bus_state(bus_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic hold(input logic [1:0] ls, input int n);
    line_state = ls;
    repeat (n) @(negedge clk);
  endtask

  task automatic wake_pulse();
    remote_wakeup_req = 1'b1;
    @(negedge clk);
    remote_wakeup_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; connect_en = 1'b0; line_state = J; remote_wakeup_req = 1'b0;
    #1 rst = 1'b0;
    #2;
    n_chk++; if ({pu, drive_k, bus_reset, suspend, resume_pulse} !== 5'b0) $display("FAIL reset_outs got %b want 00000", {pu, drive_k, bus_reset, suspend, resume_pulse}); else n_pass++;
    n_chk++; if (bus_state !== 3'd0) $display("FAIL reset_state got %0d want 0", bus_state); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_attach();
    connect_en = 1'b1;
    hold(J, 12);
    connect_en = 1'b0;
    hold(J, 1);
    n_chk++; if (pu !== 1'b0) $display("FAIL attach_drop_pu got %b want 0", pu); else n_pass++;
    connect_en = 1'b1;
    hold(J, CD - 1);
    n_chk++; if (pu !== 1'b0) $display("FAIL attach_early_pu got %b want 0", pu); else n_pass++;
    hold(J, 1);
    n_chk++; if (pu !== 1'b1) $display("FAIL attach_pu got %b want 1", pu); else n_pass++;
    n_chk++; if (bus_state !== 3'd1) $display("FAIL attach_state got %0d want 1", bus_state); else n_pass++;
    hold(K, 3);
    hold(J, 2);
    n_chk++; if (bus_state !== 3'd1) $display("FAIL attach_ignore_k got %0d want 1", bus_state); else n_pass++;
  endtask

  task automatic test_bus_reset();
    hold(SE0, SR);
    n_chk++; if (bus_reset !== 1'b0) $display("FAIL rst_first_early got %b want 0", bus_reset); else n_pass++;
    hold(SE0, 4);
    n_chk++; if (bus_reset !== 1'b1 || bus_state !== 3'd2) $display("FAIL rst_first got %b/%0d want 1/2", bus_reset, bus_state); else n_pass++;
    hold(J, 1);
    n_chk++; if (bus_reset !== 1'b1) $display("FAIL rst_hold got %b want 1", bus_reset); else n_pass++;
    hold(J, 1);
    n_chk++; if (bus_reset !== 1'b0 || bus_state !== 3'd3) $display("FAIL rst_exit got %b/%0d want 0/3", bus_reset, bus_state); else n_pass++;
    hold(SE0, SR - 1);
    hold(J, 2);
    n_chk++; if (bus_reset !== 1'b0 || bus_state !== 3'd3) $display("FAIL rst_short got %b/%0d want 0/3", bus_reset, bus_state); else n_pass++;
    hold(SE0, SR);
    hold(J, 1);
    n_chk++; if (bus_reset !== 1'b1 || bus_state !== 3'd2) $display("FAIL rst_exact got %b/%0d want 1/2", bus_reset, bus_state); else n_pass++;
    hold(J, 1);
    n_chk++; if (bus_state !== 3'd3) $display("FAIL rst_active got %0d want 3", bus_state); else n_pass++;
    hold(SE0, 5);
    hold(SE1, 1);
    hold(SE0, 5);
    hold(J, 1);
    n_chk++; if (bus_reset !== 1'b0 || bus_state !== 3'd3) $display("FAIL rst_se1_break got %b/%0d want 0/3", bus_reset, bus_state); else n_pass++;
  endtask

  task automatic test_suspend();
    hold(K, 1);
    hold(J, 30);
    hold(K, 1);
    hold(J, IS);
    n_chk++; if (suspend !== 1'b0 || bus_state !== 3'd3) $display("FAIL susp_early got %b/%0d want 0/3", suspend, bus_state); else n_pass++;
    hold(J, 1);
    n_chk++; if (suspend !== 1'b1 || bus_state !== 3'd4) $display("FAIL susp_enter got %b/%0d want 1/4", suspend, bus_state); else n_pass++;
  endtask

  task automatic test_host_resume();
    hold(K, 1);
    n_chk++; if (bus_state !== 3'd4) $display("FAIL res_lat got %0d want 4", bus_state); else n_pass++;
    hold(K, 4);
    n_chk++; if (bus_state !== 3'd5 || suspend !== 1'b1) $display("FAIL res_state got %0d/%b want 5/1", bus_state, suspend); else n_pass++;
    hold(SE0, 1);
    n_chk++; if (resume_pulse !== 1'b0 || suspend !== 1'b1) $display("FAIL res_eop_lat got %b/%b want 0/1", resume_pulse, suspend); else n_pass++;
    hold(SE0, 1);
    n_chk++; if (resume_pulse !== 1'b1 || suspend !== 1'b0 || bus_state !== 3'd3) $display("FAIL res_exit got %b/%b/%0d want 1/0/3", resume_pulse, suspend, bus_state); else n_pass++;
    hold(J, 1);
    n_chk++; if (resume_pulse !== 1'b0) $display("FAIL res_pulse_len got %b want 0", resume_pulse); else n_pass++;
  endtask

  task automatic test_remote_wakeup();
    hold(J, IS - 1);
    n_chk++; if (suspend !== 1'b0) $display("FAIL wk_susp_early got %b want 0", suspend); else n_pass++;
    hold(J, 1);
    n_chk++; if (suspend !== 1'b1) $display("FAIL wk_susp got %b want 1", suspend); else n_pass++;
    hold(J, 20);
    wake_pulse();
    n_chk++; if (drive_k !== 1'b0 || bus_state !== 3'd4) $display("FAIL wk_too_early got %b/%0d want 0/4", drive_k, bus_state); else n_pass++;
    hold(J, WI - 22);
    wake_pulse();
    n_chk++; if (drive_k !== 1'b0 || bus_state !== 3'd4) $display("FAIL wk_one_short got %b/%0d want 0/4", drive_k, bus_state); else n_pass++;
    wake_pulse();
    n_chk++; if (drive_k !== 1'b1 || bus_state !== 3'd6 || suspend !== 1'b1) $display("FAIL wk_start got %b/%0d/%b want 1/6/1", drive_k, bus_state, suspend); else n_pass++;
    hold(K, WD - 1);
    n_chk++; if (drive_k !== 1'b1) $display("FAIL wk_drive_hold got %b want 1", drive_k); else n_pass++;
    hold(K, 1);
    n_chk++; if (drive_k !== 1'b0 || bus_state !== 3'd5) $display("FAIL wk_drive_end got %b/%0d want 0/5", drive_k, bus_state); else n_pass++;
    hold(K, 3);
    hold(SE0, 2);
    n_chk++; if (resume_pulse !== 1'b1 || bus_state !== 3'd3) $display("FAIL wk_eop got %b/%0d want 1/3", resume_pulse, bus_state); else n_pass++;
    hold(J, 1);
  endtask

  task automatic test_suspend_reset();
    hold(J, IS);
    n_chk++; if (suspend !== 1'b1) $display("FAIL sr_susp got %b want 1", suspend); else n_pass++;
    hold(SE0, SR);
    n_chk++; if (bus_state !== 3'd4) $display("FAIL sr_early got %0d want 4", bus_state); else n_pass++;
    hold(J, 1);
    n_chk++; if ({bus_reset, suspend, resume_pulse} !== 3'b100 || bus_state !== 3'd2) $display("FAIL sr_reset got %b/%0d want 100/2", {bus_reset, suspend, resume_pulse}, bus_state); else n_pass++;
    hold(J, 1);
    n_chk++; if (bus_state !== 3'd3 || resume_pulse !== 1'b0) $display("FAIL sr_active got %0d/%b want 3/0", bus_state, resume_pulse); else n_pass++;
  endtask

  task automatic test_async_reset();
    hold(J, IS + 5);
    hold(J, WI + 1);
    wake_pulse();
    hold(K, 5);
    n_chk++; if (drive_k !== 1'b1) $display("FAIL ar_pre got %b want 1", drive_k); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_chk++; if ({drive_k, pu, suspend} !== 3'b000 || bus_state !== 3'd0) $display("FAIL ar_async got %b/%0d want 000/0", {drive_k, pu, suspend}, bus_state); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    hold(J, CD - 1);
    n_chk++; if (pu !== 1'b0) $display("FAIL ar_reattach_early got %b want 0", pu); else n_pass++;
    hold(J, 1);
    n_chk++; if (pu !== 1'b1) $display("FAIL ar_reattach got %b want 1", pu); else n_pass++;
  endtask

  task automatic test_detach();
    connect_en = 1'b0;
    hold(J, 1);
    n_chk++; if (pu !== 1'b0 || bus_state !== 3'd0) $display("FAIL detach got %b/%0d want 0/0", pu, bus_state); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_attach();
    test_bus_reset();
    test_suspend();
    test_host_resume();
    test_remote_wakeup();
    test_suspend_reset();
    test_async_reset();
    test_detach();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
